// File: rtl/clk_rst_ctrl.sv
// Clock-enable and reset controller: lock synchroniser, reset-hold FSM and NUM_CH
// programmable clock-enable strobes. Define CLKGEN_HEARTBEAT_EN to add the heartbeat output.
module clk_rst_ctrl #(
    parameter int                NUM_CH      = 2,
    parameter int                DIV_W       = 20,
    parameter logic [DIV_W-1:0]  DIV_DEFAULT = 20'h7FFFF,
    parameter int                SYNC_STAGES = 3,
    parameter int                HOLD_CYCLES = 16,
    parameter int                HB_BIT      = 23
) (
    input  logic                    CLK_SYS,
    input  logic                    resetn,
    input  logic                    pll_locked,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic [NUM_CH*DIV_W-1:0] div_value,
`ifdef CLKGEN_HEARTBEAT_EN
    output logic                    heartbeat,
`endif
    output logic                    rst_out_n,
    output logic                    rst_out_p,
    output logic [NUM_CH-1:0]       ce_pulse,
    output logic [NUM_CH-1:0]       ce_level
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   lock_s;
    state_t                 state;
    logic [HOLD_W-1:0]      hold_cnt;
    logic                   run_ok;
    logic [DIV_W-1:0]       shadow [NUM_CH];
    logic [DIV_W-1:0]       cnt    [NUM_CH];

    // Lock synchroniser
    always_ff @(posedge CLK_SYS or negedge resetn) begin
        if (!resetn) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock_s = sync_p0[SYNC_STAGES-1];

    // Reset sequencing FSM; rst_out_n tracks the state register edge for edge
    always_ff @(posedge CLK_SYS or negedge resetn) begin
        if (!resetn) begin
            state     <= WAIT_LOCK;
            hold_cnt  <= '0;
            rst_out_n <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    hold_cnt <= '0;
                    if (lock_s) state <= HOLD;
                end
                HOLD: begin
                    if (!lock_s) begin
                        state    <= WAIT_LOCK;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state     <= RUN;
                        rst_out_n <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state     <= WAIT_LOCK;
                        rst_out_n <= 1'b0;
                    end
                end
                default: begin
                    state     <= WAIT_LOCK;
                    rst_out_n <= 1'b0;
                end
            endcase
        end
    end

    assign rst_out_p = ~rst_out_n;

    // Strobes stop on the same edge the FSM leaves RUN, so lock loss wins over a load
    assign run_ok = (state == RUN) && lock_s;

    // Channel counters and strobe registers
    always_ff @(posedge CLK_SYS or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= DIV_DEFAULT;
                cnt[i]    <= '0;
            end
            ce_pulse <= '0;
            ce_level <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (div_load[i]) shadow[i] <= div_value[i*DIV_W +: DIV_W];
                if (!(run_ok && ch_enable[i])) begin
                    cnt[i]      <= '0;
                    ce_pulse[i] <= 1'b0;
                    ce_level[i] <= 1'b0;
                end else if (div_load[i]) begin
                    cnt[i]      <= '0;
                    ce_pulse[i] <= 1'b0;
                end else if (cnt[i] == shadow[i]) begin
                    cnt[i]      <= '0;
                    ce_pulse[i] <= 1'b1;
                    ce_level[i] <= ~ce_level[i];
                end else begin
                    cnt[i]      <= cnt[i] + 1'b1;
                    ce_pulse[i] <= 1'b0;
                end
            end
        end
    end

`ifdef CLKGEN_HEARTBEAT_EN
    logic [HB_BIT:0] hb_cnt;

    always_ff @(posedge CLK_SYS or negedge resetn) begin
        if (!resetn) begin
            hb_cnt <= '0;
        end else if (state == RUN) begin
            hb_cnt <= hb_cnt + 1'b1;
        end else begin
            hb_cnt <= '0;
        end
    end

    assign heartbeat = hb_cnt[HB_BIT];
`endif

endmodule
